// File: rtl/pio_mem_pkg.sv
// ---------------------------------------------------------------------------
// pio_mem_pkg
// Shared definitions for the Nios PIO memory responder:
//   - op_e        : command opcodes carried in interlock[3:1]
//   - state_e     : responder FSM state encodings
//   - BAD_OP_WORD : result word returned for an unknown opcode
//   - IL_*        : bit positions of the fields inside the interlock PIO
// ---------------------------------------------------------------------------
package pio_mem_pkg;

   typedef enum logic [2:0] {
      OP_READ  = 3'b000,
      OP_WRITE = 3'b001,
      OP_FILL  = 3'b010,
      OP_SUM   = 3'b011
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_WAIT = 3'd1,
      S_WR      = 3'd2,
      S_FILL    = 3'd3,
      S_SUM_RUN = 3'd4,
      S_BADOP   = 3'd5,
      S_DONE    = 3'd6
   } state_e;

   localparam logic [15:0] BAD_OP_WORD = 16'hDEAD;

   // interlock bit fields
   localparam int IL_REQ     = 0;
   localparam int IL_OP_LO   = 1;
   localparam int IL_OP_HI   = 3;
   localparam int IL_RSVD_LO = 4;
   localparam int IL_RSVD_HI = 7;

endpackage

// File: rtl/pio_mem_responder_if.sv
// ---------------------------------------------------------------------------
// pio_mem_responder_if
// Bundle of the PIO signals exchanged between the Nios side and the
// fabric memory responder.
//   address_sig : start/target address          (master -> slave)
//   data_sig    : write/fill data               (master -> slave)
//   wren        : write qualifier for WRITE     (master -> slave)
//   interlock   : [0] request toggle, [3:1] op  (master -> slave)
//   q_sig       : result word                   (slave -> master)
//   ack_toggle  : flips once per completed cmd  (slave -> master)
//   busy        : command in progress           (slave -> master)
// ---------------------------------------------------------------------------
interface pio_mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] address_sig;
   logic [DATA_W-1:0] data_sig;
   logic              wren;
   logic [7:0]        interlock;
   logic [DATA_W-1:0] q_sig;
   logic              ack_toggle;
   logic              busy;

   modport master (
      output address_sig, data_sig, wren, interlock,
      input  q_sig, ack_toggle, busy
   );

   modport slave (
      input  address_sig, data_sig, wren, interlock,
      output q_sig, ack_toggle, busy
   );
endinterface

// File: rtl/pio_mem_ram.sv
// ---------------------------------------------------------------------------
// pio_mem_ram
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, one-cycle read latency.
// Read returns the old contents when reading and writing the same address.
//   clk   : clock
//   we    : write enable
//   addr  : read/write address
//   wdata : write data
//   rdata : registered read data (valid the cycle after addr)
// ---------------------------------------------------------------------------
module pio_mem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/pio_mem_responder.sv
// ---------------------------------------------------------------------------
// pio_mem_responder
// Fabric-side responder for the Nios PIO memory port. Each net change of
// interlock[0] seen while idle starts one command (READ, WRITE, FILL, SUM or
// an unknown opcode) against a local RAM; the result appears on q_sig and
// ack_toggle flips in the same cycle that busy drops.
//   clk_clk       : clock, all logic on the rising edge
//   reset_reset_n : synchronous active-low reset (RAM contents kept)
//   pio           : PIO bundle, slave side (see pio_mem_responder_if)
// ---------------------------------------------------------------------------
module pio_mem_responder
   import pio_mem_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                DATA_W      = 16,
   parameter logic [DATA_W-1:0] BAD_OP_WORD = pio_mem_pkg::BAD_OP_WORD
) (
   input logic                clk_clk,
   input logic                reset_reset_n,
   pio_mem_responder_if.slave pio
);

   localparam logic [2:0] ST_IDLE    = S_IDLE;
   localparam logic [2:0] ST_RD_WAIT = S_RD_WAIT;
   localparam logic [2:0] ST_WR      = S_WR;
   localparam logic [2:0] ST_FILL    = S_FILL;
   localparam logic [2:0] ST_SUM_RUN = S_SUM_RUN;
   localparam logic [2:0] ST_BADOP   = S_BADOP;
   localparam logic [2:0] ST_DONE    = S_DONE;

   // One past the top address; the extra counter bit marks "loop finished".
   localparam logic [ADDR_W:0] TOP_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        state_reg;
   logic              req_prev_reg;
   logic [ADDR_W-1:0] start_reg;
   logic [ADDR_W:0]   cnt_reg;
   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] acc_reg;
   logic              rd_valid_reg;
   logic [DATA_W-1:0] q_reg;
   logic              ack_reg;
   logic              busy_reg;

   logic              cnt_top;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;
   logic              finish;
   logic [DATA_W-1:0] result;
   logic              unused_rsvd;

   assign unused_rsvd = ^pio.interlock[IL_RSVD_HI:IL_RSVD_LO];
   assign cnt_top     = cnt_reg[ADDR_W];
   // WRITE issues its single store in WR; FILL stores until the counter
   // reaches the terminal value.
   assign ram_we      = (state_reg == ST_WR) || ((state_reg == ST_FILL) && !cnt_top);

   pio_mem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk_clk),
      .we    (ram_we),
      .addr  (cnt_reg[ADDR_W-1:0]),
      .wdata (data_reg),
      .rdata (ram_rdata)
   );

   // Completion condition and result word for the active state.
   always_comb begin
      finish = 1'b0;
      result = q_reg;
      case (state_reg)
         ST_RD_WAIT: begin
            finish = rd_valid_reg;
            result = ram_rdata;
         end
         ST_WR: begin
            finish = 1'b1;
            result = data_reg;
         end
         ST_FILL: begin
            finish = cnt_top;
            result = DATA_W'(TOP_CNT - {1'b0, start_reg});
         end
         ST_SUM_RUN: begin
            // wait for the last read to be folded into the accumulator
            finish = cnt_top && !rd_valid_reg;
            result = acc_reg;
         end
         ST_BADOP: begin
            finish = 1'b1;
            result = BAD_OP_WORD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_reg    <= ST_IDLE;
         req_prev_reg <= 1'b0;
         start_reg    <= '0;
         cnt_reg      <= '0;
         data_reg     <= '0;
         acc_reg      <= '0;
         rd_valid_reg <= 1'b0;
         q_reg        <= '0;
         ack_reg      <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         rd_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               req_prev_reg <= pio.interlock[IL_REQ];
               if (pio.interlock[IL_REQ] != req_prev_reg) begin
                  start_reg <= pio.address_sig;
                  cnt_reg   <= {1'b0, pio.address_sig};
                  data_reg  <= pio.data_sig;
                  acc_reg   <= '0;
                  busy_reg  <= 1'b1;
                  case (pio.interlock[IL_OP_HI:IL_OP_LO])
                     OP_READ:  state_reg <= ST_RD_WAIT;
                     OP_WRITE: state_reg <= pio.wren ? ST_WR : ST_RD_WAIT;
                     OP_FILL:  state_reg <= ST_FILL;
                     OP_SUM:   state_reg <= ST_SUM_RUN;
                     default:  state_reg <= ST_BADOP;
                  endcase
               end
            end
            ST_RD_WAIT: begin
               // first cycle issues the read, second consumes it
               rd_valid_reg <= !rd_valid_reg;
            end
            ST_FILL: begin
               if (!cnt_top) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_SUM_RUN: begin
               if (!cnt_top) begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
               rd_valid_reg <= !cnt_top;
               if (rd_valid_reg) begin
                  acc_reg <= acc_reg + ram_rdata;
               end
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: ;
         endcase

         if (finish) begin
            q_reg     <= result;
            ack_reg   <= ~ack_reg;
            busy_reg  <= 1'b0;
            state_reg <= ST_DONE;
         end
      end
   end

   assign pio.q_sig      = q_reg;
   assign pio.ack_toggle = ack_reg;
   assign pio.busy       = busy_reg;

endmodule

// File: tb/tb_pio_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_pio_mem_responder
// Self-checking bench: each test task drives commands through the PIO
// interface and compares the result word, completion latency and busy
// behaviour against a behavioural memory model kept in ref_mem.
// ---------------------------------------------------------------------------
module tb_pio_mem_responder;
   import pio_mem_pkg::*;

   localparam int AW = 8;
   localparam int DW = 16;

   logic clk_clk       = 1'b0;
   logic reset_reset_n = 1'b0;
   int   checks        = 0;
   int   errors        = 0;

   logic [15:0] ref_mem [0:255];

   pio_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) pio ();

   pio_mem_responder #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .BAD_OP_WORD (16'hDEAD)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pio           (pio)
   );

   always #5 clk_clk = ~clk_clk;

   // Reference model: applies one command to ref_mem, returns expected q
   // and completion latency in cycles after recognition.
   function automatic void model_cmd(input logic [2:0] op, input logic [7:0] a,
                                     input logic [15:0] d, input logic w,
                                     output logic [15:0] eq, output int el);
      int n;
      int unsigned s;
      n = 256 - int'(a);
      s = 0;
      case (op)
         3'b000: begin eq = ref_mem[a]; el = 3; end
         3'b001: begin
            if (w) begin ref_mem[a] = d; eq = d; el = 2; end
            else   begin eq = ref_mem[a]; el = 3; end
         end
         3'b010: begin
            for (int i = int'(a); i < 256; i++) ref_mem[i] = d;
            eq = 16'(n);
            el = n + 2;
         end
         3'b011: begin
            for (int i = int'(a); i < 256; i++) s += 32'(ref_mem[i]);
            eq = s[15:0];
            el = n + 3;
         end
         default: begin eq = 16'hDEAD; el = 2; end
      endcase
   endfunction

   // Issues one command by toggling interlock[0] and waits (bounded) for
   // the ack. lat = cycles from recognition to completion, -1 on timeout.
   // Address/data/wren are scrambled after acceptance; toggles>0 adds extra
   // interlock[0] flips while the command is busy.
   task automatic run_cmd(input logic [2:0] op, input logic [7:0] a,
                          input logic [15:0] d, input logic w, input int toggles,
                          output logic [15:0] q_o, output int lat, output bit busy_ok);
      logic ack0;
      ack0 = pio.ack_toggle;
      pio.address_sig = a;
      pio.data_sig    = d;
      pio.wren        = w;
      pio.interlock   = {4'($urandom), op, ~pio.interlock[0]};
      lat     = -1;
      busy_ok = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk_clk);
         if (k == 1) begin
            pio.address_sig = 8'($urandom);
            pio.data_sig    = 16'($urandom);
            pio.wren        = 1'($urandom);
         end
         if ((toggles >= 1 && k == 5) || (toggles >= 2 && k == 10))
            pio.interlock[0] = ~pio.interlock[0];
         if (pio.ack_toggle !== ack0) begin
            lat = k;
            if (pio.busy !== 1'b0) busy_ok = 1'b0;
            break;
         end
         if (pio.busy !== 1'b1) busy_ok = 1'b0;
      end
      q_o = pio.q_sig;
      $display("cmd op=%0d addr=%h data=%h wren=%b -> q=%h lat=%0d", op, a, d, w, q_o, lat);
      @(negedge clk_clk);
   endtask

   task automatic test_reset();
      pio.address_sig = '0;
      pio.data_sig    = '0;
      pio.wren        = 1'b0;
      pio.interlock   = '0;
      reset_reset_n   = 1'b0;
      repeat (3) @(negedge clk_clk);
      checks++; if (pio.q_sig !== 16'h0) begin errors++; $display("FAIL reset_q: got %h expected 0000", pio.q_sig); end
      checks++; if (pio.ack_toggle !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", pio.ack_toggle); end
      checks++; if (pio.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", pio.busy); end
      reset_reset_n = 1'b1;
      repeat (5) @(negedge clk_clk);
      checks++; if (pio.ack_toggle !== 1'b0 || pio.busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle: ack=%b busy=%b expected 0/0", pio.ack_toggle, pio.busy);
      end
   endtask

   task automatic test_write_read();
      logic [2:0]  ops [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
      logic [15:0] dat [4] = '{16'h1234, 16'h0000, 16'hBEEF, 16'h0000};
      logic        wrn [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] q_o, eq;
      int lat, el;
      bit bok;
      for (int i = 0; i < 4; i++) begin
         run_cmd(ops[i], 8'h10, dat[i], wrn[i], 0, q_o, lat, bok);
         model_cmd(ops[i], 8'h10, dat[i], wrn[i], eq, el);
         checks++; if (q_o !== eq) begin errors++; $display("FAIL wr_rd_q[%0d]: got %h expected %h", i, q_o, eq); end
         checks++; if (lat != el) begin errors++; $display("FAIL wr_rd_lat[%0d]: got %0d expected %0d", i, lat, el); end
         checks++; if (!bok) begin errors++; $display("FAIL wr_rd_busy[%0d]: busy got wrong expected high until ack", i); end
      end
   endtask

   task automatic test_fill();
      logic [15:0] q_o, eq;
      int lat, el;
      bit bok;
      logic [15:0] d0;
      d0 = 16'($urandom);
      run_cmd(3'b010, 8'h00, d0, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b010, 8'h00, d0, 1'b0, eq, el);
      checks++; if (q_o !== eq || lat != el) begin errors++; $display("FAIL fill_all: got q=%h lat=%0d expected q=%h lat=%0d", q_o, lat, eq, el); end
      run_cmd(3'b001, 8'hFB, 16'h7777, 1'b1, 0, q_o, lat, bok);
      model_cmd(3'b001, 8'hFB, 16'h7777, 1'b1, eq, el);
      run_cmd(3'b010, 8'hFC, 16'h0005, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b010, 8'hFC, 16'h0005, 1'b0, eq, el);
      checks++; if (q_o !== eq) begin errors++; $display("FAIL fill_fc_q: got %h expected %h", q_o, eq); end
      checks++; if (lat != el) begin errors++; $display("FAIL fill_fc_lat: got %0d expected %0d", lat, el); end
      checks++; if (!bok) begin errors++; $display("FAIL fill_fc_busy: busy got wrong expected high until ack"); end
      for (int a = 'hFB; a <= 'hFF; a++) begin
         run_cmd(3'b000, 8'(a), 16'h0, 1'b0, 0, q_o, lat, bok);
         model_cmd(3'b000, 8'(a), 16'h0, 1'b0, eq, el);
         checks++; if (q_o !== eq) begin errors++; $display("FAIL fill_readback[%h]: got %h expected %h", a, q_o, eq); end
      end
   endtask

   task automatic test_sum();
      logic [15:0] q_o, eq;
      int lat, el;
      bit bok;
      run_cmd(3'b011, 8'hFC, 16'h0, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b011, 8'hFC, 16'h0, 1'b0, eq, el);
      checks++; if (q_o !== eq) begin errors++; $display("FAIL sum_fc_q: got %h expected %h", q_o, eq); end
      checks++; if (lat != el) begin errors++; $display("FAIL sum_fc_lat: got %0d expected %0d", lat, el); end
      checks++; if (!bok) begin errors++; $display("FAIL sum_fc_busy: busy got wrong expected high until ack"); end
      run_cmd(3'b010, 8'h00, 16'hFFFF, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b010, 8'h00, 16'hFFFF, 1'b0, eq, el);
      run_cmd(3'b011, 8'hFE, 16'h0, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b011, 8'hFE, 16'h0, 1'b0, eq, el);
      checks++; if (q_o !== eq || lat != el) begin errors++; $display("FAIL sum_wrap: got q=%h lat=%0d expected q=%h lat=%0d", q_o, lat, eq, el); end
      run_cmd(3'b011, 8'h00, 16'h0, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b011, 8'h00, 16'h0, 1'b0, eq, el);
      checks++; if (q_o !== eq || lat != el) begin errors++; $display("FAIL sum_all: got q=%h lat=%0d expected q=%h lat=%0d", q_o, lat, eq, el); end
   endtask

   task automatic test_badop();
      logic [15:0] q_o, eq;
      int lat, el;
      bit bok;
      run_cmd(3'b101, 8'h00, 16'h4321, 1'b1, 0, q_o, lat, bok);
      model_cmd(3'b101, 8'h00, 16'h4321, 1'b1, eq, el);
      checks++; if (q_o !== eq) begin errors++; $display("FAIL badop_q: got %h expected %h", q_o, eq); end
      checks++; if (lat != el) begin errors++; $display("FAIL badop_lat: got %0d expected %0d", lat, el); end
      run_cmd(3'b000, 8'h00, 16'h0, 1'b0, 0, q_o, lat, bok);
      model_cmd(3'b000, 8'h00, 16'h0, 1'b0, eq, el);
      checks++; if (q_o !== eq) begin errors++; $display("FAIL badop_nowrite: got %h expected %h", q_o, eq); end
   endtask

   task automatic test_toggle_while_busy();
      logic [15:0] q_o, eq, d;
      int lat, el, got;
      bit bok, extra;
      logic ack0;
      // two flips while busy cancel: no follow-up command
      d = 16'($urandom);
      run_cmd(3'b010, 8'h00, d, 1'b0, 2, q_o, lat, bok);
      model_cmd(3'b010, 8'h00, d, 1'b0, eq, el);
      checks++; if (q_o !== eq || lat != el) begin errors++; $display("FAIL dbl_toggle_fill: got q=%h lat=%0d expected q=%h lat=%0d", q_o, lat, eq, el); end
      ack0  = pio.ack_toggle;
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk_clk);
         if (pio.ack_toggle !== ack0 || pio.busy !== 1'b0) extra = 1'b1;
      end
      checks++; if (extra) begin errors++; $display("FAIL dbl_toggle_quiet: got extra activity expected none"); end
      // one flip while busy: exactly one more command on return to IDLE
      d = 16'($urandom);
      run_cmd(3'b010, 8'h80, d, 1'b0, 1, q_o, lat, bok);
      model_cmd(3'b010, 8'h80, d, 1'b0, eq, el);
      checks++; if (q_o !== eq || lat != el) begin errors++; $display("FAIL one_toggle_fill: got q=%h lat=%0d expected q=%h lat=%0d", q_o, lat, eq, el); end
      pio.interlock[3:1] = 3'b000;
      pio.address_sig    = 8'h90;
      pio.wren           = 1'b0;
      ack0 = pio.ack_toggle;
      got  = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk_clk);
         if (pio.ack_toggle !== ack0) begin got = k; break; end
      end
      model_cmd(3'b000, 8'h90, 16'h0, 1'b0, eq, el);
      $display("pending cmd op=0 addr=90 -> q=%h lat=%0d", pio.q_sig, got);
      checks++; if (got != el) begin errors++; $display("FAIL one_toggle_lat: got %0d expected %0d", got, el); end
      checks++; if (pio.q_sig !== eq) begin errors++; $display("FAIL one_toggle_q: got %h expected %h", pio.q_sig, eq); end
      ack0  = pio.ack_toggle;
      extra = 1'b0;
      repeat (20) begin
         @(negedge clk_clk);
         if (pio.ack_toggle !== ack0) extra = 1'b1;
      end
      checks++; if (extra) begin errors++; $display("FAIL one_toggle_once: got second ack expected none"); end
   endtask

   task automatic test_random();
      logic [15:0] q_o, eq, d;
      logic [7:0]  a;
      logic [2:0]  op;
      logic        w;
      int lat, el;
      bit bok;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         if (op == 3'b010 || op == 3'b011) a = 8'($urandom_range(128, 255));
         d  = 16'($urandom);
         w  = 1'($urandom);
         run_cmd(op, a, d, w, 0, q_o, lat, bok);
         model_cmd(op, a, d, w, eq, el);
         checks++; if (q_o !== eq) begin errors++; $display("FAIL rand_q[%0d]: got %h expected %h", i, q_o, eq); end
         checks++; if (lat != el) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", i, lat, el); end
         checks++; if (!bok) begin errors++; $display("FAIL rand_busy[%0d]: busy got wrong expected high until ack", i); end
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [15:0] q_o, eq, d_new, old200;
      int lat, el;
      bit bok, extra;
      run_cmd(3'b001, 8'h33, 16'hA5A5, 1'b1, 0, q_o, lat, bok);
      model_cmd(3'b001, 8'h33, 16'hA5A5, 1'b1, eq, el);
      if (pio.ack_toggle == 1'b0) begin
         run_cmd(3'b001, 8'h33, 16'hA5A5, 1'b1, 0, q_o, lat, bok);
         model_cmd(3'b001, 8'h33, 16'hA5A5, 1'b1, eq, el);
      end
      old200 = ref_mem[200];
      d_new  = ~old200;
      pio.address_sig = 8'h00;
      pio.data_sig    = d_new;
      pio.wren        = 1'b0;
      pio.interlock   = {4'h0, 3'b010, ~pio.interlock[0]};
      repeat (50) @(negedge clk_clk);
      reset_reset_n = 1'b0;
      pio.interlock = '0;
      @(negedge clk_clk);
      $display("reset mid-fill -> q=%h ack=%b busy=%b", pio.q_sig, pio.ack_toggle, pio.busy);
      checks++; if (pio.q_sig !== 16'h0) begin errors++; $display("FAIL abort_q: got %h expected 0000", pio.q_sig); end
      checks++; if (pio.ack_toggle !== 1'b0) begin errors++; $display("FAIL abort_ack: got %b expected 0", pio.ack_toggle); end
      checks++; if (pio.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", pio.busy); end
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      extra = 1'b0;
      repeat (300) begin
         @(negedge clk_clk);
         if (pio.ack_toggle !== 1'b0 || pio.busy !== 1'b0) extra = 1'b1;
      end
      checks++; if (extra) begin errors++; $display("FAIL abort_no_ack: got activity expected none"); end
      run_cmd(3'b000, 8'd5, 16'h0, 1'b0, 0, q_o, lat, bok);
      checks++; if (q_o !== d_new) begin errors++; $display("FAIL abort_partial_lo: got %h expected %h", q_o, d_new); end
      run_cmd(3'b000, 8'd200, 16'h0, 1'b0, 0, q_o, lat, bok);
      checks++; if (q_o !== old200) begin errors++; $display("FAIL abort_partial_hi: got %h expected %h", q_o, old200); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fill();
      test_sum();
      test_badop();
      test_toggle_while_busy();
      test_random();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pio_mem_responder.md
# pio_mem_responder

Fabric-side responder for the Nios PIO memory port. It samples the address, data, write-enable and interlock PIO outputs, executes one command per interlock toggle against a local 256×16 RAM, and returns the result on the 16-bit q PIO input. It acknowledges each command by toggling an ack line that software polls through a spare PIO input.

## Interface
Parameters:
- ADDR_W, 8: RAM address width; depth is 2^ADDR_W.
- DATA_W, 16: RAM word width.
- BAD_OP_WORD, 16'hDEAD: value returned on q for an unknown opcode.

Ports:
- clk_clk, in, 1: sole clock; one clock, all logic rising-edge.
- reset_reset_n, in, 1: reset is synchronous and active-low.
- address_sig, in, ADDR_W: start or target address from PIO.
- data_sig, in, DATA_W: write or fill data from PIO.
- wren, in, 1: write qualifier for the WRITE opcode.
- interlock, in, 8: bit0 is the request toggle; bits[3:1] are the opcode; bits[7:4] are reserved and ignored.
- q_sig, out, DATA_W: result word to PIO.
- ack_toggle, out, 1: flips once per completed command.
- busy, out, 1: high from command acceptance until the ack flips.

## Operation
- Request detect:
  - req_prev is a register that follows interlock[0] only while in IDLE.
  - A request is recognised when state is IDLE and interlock[0] ≠ req_prev.
  - All other PIO fields are latched in that same cycle.
- Toggles while busy are not tracked. When the block returns to IDLE, a net change versus req_prev is a new request. Two toggles while busy cancel out.
- Opcodes:
  - 000 READ: q ← RAM[addr].
  - 001 WRITE: if wren=1, RAM[addr] ← data and q ← data. If wren=0, no memory change and q ← RAM[addr], i.e. it behaves as READ.
  - 010 FILL: RAM[a] ← data for a = addr..2^ADDR_W−1. q ← word count, computed as 2^ADDR_W − addr (addr=0 gives 256, truncated to DATA_W).
  - 011 SUM: q ← Σ RAM[a] for a = addr..2^ADDR_W−1, mod 2^DATA_W.
  - 1xx: q ← BAD_OP_WORD, no memory change.
- States: IDLE → {RD_WAIT, WR, FILL, SUM_RUN, BADOP} → DONE → IDLE.
  - RD_WAIT: covers the 1-cycle RAM read latency.
  - FILL: issues one write per cycle; the address counter stops at the top address.
  - SUM_RUN: issues reads back-to-back with a pipelined accumulate; it drains the final read before moving to DONE.
  - DONE: q_sig and ack_toggle update together, and busy drops.
- Address counter is ADDR_W+1 bits so the top address terminates the loop without wrapping to 0.
- q_sig holds its value until the next completion.

## Timing
- Let T be the cycle the request is recognised (latched). Completion means the cycle q_sig and ack_toggle change:
  - READ: T+3.
  - WRITE: T+2.
  - FILL: T+N+2, where N = 2^ADDR_W − addr.
  - SUM: T+N+3.
  - BADOP: T+2.
- busy is high from T+1 through the cycle before completion.
- RAM write data is visible to a READ recognised any cycle after completion.
- Reset values: q_sig=0, ack_toggle=0, busy=0, state=IDLE, req_prev=0. RAM contents are not reset.
- Reset mid-command aborts it: no ack, and any FILL is partially applied.
- After reset, an interlock[0]=1 is seen as a request on the first IDLE cycle. Software must clear interlock[0] during reset.

## Structure
- Shared package pio_mem_pkg holds:
  - the opcode enum (OP_READ, OP_WRITE, OP_FILL, OP_SUM);
  - the state enum;
  - BAD_OP_WORD;
  - the interlock bit-field indices.
- One sub-module, pio_mem_ram: single-port 256×16 synchronous RAM, 1-cycle read latency, write-first not required.
- The top-level contains the FSM, address counter, accumulator and output registers.

## Test plan
- Reset with interlock=0, then WRITE addr 8'h10, data 16'h1234, wren=1 and toggle. Expect ack flip at T+2 with q=16'h1234. A following READ of 8'h10 returns 16'h1234 at T+3.
- FILL addr 8'hFC with data 16'h0005. Expect q=4 at T+6. READs of FC..FF return 5; a READ of FB is unchanged.
- After that fill, SUM addr 8'hFC. Expect q=16'h0014 at T+7. A SUM producing overflow wraps mod 2^16: fill 0 with 16'hFFFF, then SUM 8'hFE gives 16'hFFFE.
- Opcode 3'b101 at addr 8'h00. Expect q=16'hDEAD at T+2 and no RAM change.
- Toggle interlock[0] twice during a FILL from 0. Expect no second ack after completion. Toggle once during busy: exactly one extra command is serviced on return to IDLE.
- Assert reset_reset_n low mid-FILL. Expect q=0, ack_toggle=0, busy=0 the next cycle, and no ack for the aborted command.
